// File: rtl/komut_getirici.sv
// Instruction fetch stage: keeps the PC, issues in-order word reads and buffers
// returned instructions in a small FIFO feeding the decoder over valid/ready.
module komut_getirici #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_istek,
    output logic [31:0] mem_adres,
    input  logic        mem_veri_gecerli,
    input  logic [31:0] mem_veri,
    input  logic        dallan,
    input  logic [31:0] dallan_adres,
    output logic [31:0] komut,
    output logic [31:0] komut_pc,
    output logic        komut_gecerli,
    input  logic        komut_hazir,
    output logic        hata
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] LIMIT = (CW+1)'(DEPTH);

    // Handshake: a transfer to the decoder happens in any cycle where
    // komut_gecerli && komut_hazir are both high at the rising edge; komut and
    // komut_pc hold steady while komut_gecerli is high and komut_hazir is low.

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        DRAIN = 2'd1,
        HATA  = 2'd2
    } durum_t;

    durum_t        state, state_next;
    logic [31:0]   pc, resp_pc;
    logic [CW-1:0] count, outstanding, out_next;
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [31:0]   fifo_komut [DEPTH];
    logic [31:0]   fifo_pc    [DEPTH];
    logic          hata_r;

    logic          br_en, br_ok, br_err;
    logic          issue, resp, push, pop;
    logic [CW:0]   used;

    always_comb begin
        br_en  = dallan && (state != HATA);
        br_ok  = br_en && (dallan_adres[1:0] == 2'b00);
        br_err = br_en && (dallan_adres[1:0] != 2'b00);

        // Credits count both buffered and in-flight words, so every response
        // accepted in FETCH is guaranteed a free FIFO slot.
        used  = {1'b0, count} + {1'b0, outstanding};
        issue = !rst && (state == FETCH) && !dallan && (used < LIMIT);
        resp  = mem_veri_gecerli && (outstanding != '0);

        komut_gecerli = !rst && (count != '0) && (state != HATA);
        push = resp && (state == FETCH) && !br_en;
        pop  = komut_gecerli && komut_hazir && !br_en;

        out_next = outstanding + CW'(issue) - CW'(resp);
    end

    always_comb begin
        state_next = state;
        case (state)
            FETCH, DRAIN: begin
                if (br_err)
                    state_next = HATA;
                else if (br_ok)
                    state_next = (out_next != '0) ? DRAIN : FETCH;
                else if (state == DRAIN && out_next == '0)
                    state_next = FETCH;
            end
            default: state_next = HATA;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            resp_pc     <= RESET_PC;
            count       <= '0;
            outstanding <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            hata_r      <= 1'b0;
        end else begin
            state       <= state_next;
            outstanding <= out_next;
            if (br_err)
                hata_r <= 1'b1;

            if (br_ok) begin
                pc      <= dallan_adres;
                resp_pc <= dallan_adres;
            end else begin
                if (issue)
                    pc <= pc + 32'd4;
                if (push)
                    resp_pc <= resp_pc + 32'd4;
            end

            // Any accepted redirect empties the buffer, dropping this cycle's push/pop.
            if (br_en) begin
                count  <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + 1'b1;
                if (pop)
                    rd_ptr <= rd_ptr + 1'b1;
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            fifo_komut[wr_ptr] <= mem_veri;
            fifo_pc[wr_ptr]    <= resp_pc;
        end
    end

    assign mem_istek = issue;
    assign mem_adres = pc;
    assign komut     = fifo_komut[rd_ptr];
    assign komut_pc  = fifo_pc[rd_ptr];
    assign hata      = hata_r;

endmodule
